// File: rtl/mb_fill_seq_pkg.sv
// mb_fill_seq_pkg: shared types and MB_IN_SEL encodings for the MB0 fill sequencer
package mb_fill_seq_pkg;
  typedef enum logic [1:0] {IDLE, FILL, DRAIN, GAP} mb_fill_state_t;
  typedef logic [1:0] mb_wd_t;
  localparam logic [2:0] MB_IN_SEL_MEM   = 3'b100;
  localparam logic [2:0] MB_IN_SEL_AR    = 3'b010;
  localparam logic [2:0] MB_IN_SEL_CACHE = 3'b000;
endpackage

// File: rtl/mb_fill_seq_if.sv
// mb_fill_seq_if: request/memory/cache handshake and MB steering bundle of the fill sequencer
interface mb_fill_seq_if;
  import mb_fill_seq_pkg::*;
  logic rd_start;
  mb_wd_t start_wd;
  logic wr_load;
  logic mem_wd_valid;
  mb_wd_t mem_wd_num;
  logic mem_par_ok;
  logic nxm;
  logic cache_ack;
  logic [3:0] mb_hold;
  logic [2:0] mb_in_sel;
  mb_wd_t mb_sel;
  logic mb_sel_hold;
  logic [3:0] mb_valid;
  logic cache_wr_req;
  logic busy;
  logic done;
  logic par_err;
  modport master(
    output rd_start, start_wd, wr_load, mem_wd_valid, mem_wd_num, mem_par_ok, nxm, cache_ack,
    input mb_hold, mb_in_sel, mb_sel, mb_sel_hold, mb_valid, cache_wr_req, busy, done, par_err
  );
  modport slave(
    input rd_start, start_wd, wr_load, mem_wd_valid, mem_wd_num, mem_par_ok, nxm, cache_ack,
    output mb_hold, mb_in_sel, mb_sel, mb_sel_hold, mb_valid, cache_wr_req, busy, done, par_err
  );
endinterface

// File: rtl/mb_fill_seq_valid_track.sv
// mb_valid_track: per-word valid vector with distinct-fill counter and duplicate detect
module mb_valid_track
  import mb_fill_seq_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       set,
  input  mb_wd_t     wd,
  output logic [3:0] valid,
  output logic [2:0] cnt,
  output logic       dup
);
  assign dup = valid[wd];
  always_ff @(posedge clk)
    if (reset || clr) begin
      valid <= 4'b0000;
      cnt <= 3'd0;
    end else if (set) begin
      valid[wd] <= 1'b1;
      cnt <= cnt + 3'(!dup);
    end
endmodule

// File: rtl/mb_fill_seq.sv
// mb_fill_seq: MB0 quadword fill/drain sequencer with AR write load and NXM abort.
// Define MB_PAR_CHK_EN to capture a sticky parity error on loaded memory words.
module mb_fill_seq
  import mb_fill_seq_pkg::*;
#(
  parameter int NWORDS    = 4,
  parameter int DRAIN_GAP = 0
) (
  input logic clk,
  input logic reset,
  mb_fill_seq_if.slave bus
);
  mb_fill_state_t state, nxt;
  mb_wd_t first, ld_wd, sel;
  logic [1:0] drain_cnt, gap_cnt;
  logic [3:0] valid;
  logic [2:0] cnt;
  logic idle, go, wr, abort, mem_ld, dup, fill_done, ack, last, done_q;
  always_comb begin
    idle = state == IDLE;
    go = idle && bus.rd_start;
    wr = idle && bus.wr_load && !bus.rd_start;
    abort = !idle && bus.nxm;
    mem_ld = state == FILL && bus.mem_wd_valid && !bus.nxm;
    ld_wd = mem_ld ? bus.mem_wd_num : bus.start_wd;
    fill_done = mem_ld && !dup && cnt == 3'(NWORDS - 1);
    ack = state == DRAIN && bus.cache_ack && !bus.nxm;
    last = ack && drain_cnt == 2'(NWORDS - 1);
  end
  mb_valid_track u_trk (
    .clk(clk),
    .reset(reset),
    .clr(go || abort),
    .set(mem_ld || wr),
    .wd(ld_wd),
    .valid(valid),
    .cnt(cnt),
    .dup(dup)
  );
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= nxt;
  always_comb
    nxt = abort ? IDLE : go ? FILL : fill_done ? DRAIN : last ? IDLE :
          (ack && DRAIN_GAP > 0) ? GAP : (state == GAP && gap_cnt == 2'd0) ? DRAIN : state;
  always_ff @(posedge clk)
    if (reset) begin
      first <= 2'd0;
      sel <= 2'd0;
      drain_cnt <= 2'd0;
      gap_cnt <= 2'd0;
      done_q <= 1'b0;
    end else begin
      done_q <= abort || last || wr;
      if (go) first <= bus.start_wd;
      if (fill_done) begin
        sel <= first;
        drain_cnt <= 2'd0;
      end
      if (ack) begin
        sel <= sel + 2'd1;
        drain_cnt <= drain_cnt + 2'd1;
        gap_cnt <= 2'(DRAIN_GAP - 1);
      end else if (state == GAP) gap_cnt <= gap_cnt - 2'd1;
    end
  always_comb begin
    bus.mb_hold = (mem_ld || wr) ? ~(4'b0001 << ld_wd) : 4'b1111;
    bus.mb_in_sel = mem_ld ? MB_IN_SEL_MEM : wr ? MB_IN_SEL_AR : MB_IN_SEL_CACHE;
    bus.mb_sel = sel;
    bus.mb_sel_hold = !(ack || fill_done);
    bus.mb_valid = valid;
    bus.cache_wr_req = state == DRAIN;
    bus.busy = !idle;
    bus.done = done_q;
  end
`ifdef MB_PAR_CHK_EN
  logic par_q;
  always_ff @(posedge clk)
    if (reset || go) par_q <= 1'b0;
    else if (mem_ld && !bus.mem_par_ok) par_q <= 1'b1;
  assign bus.par_err = par_q;
`else
  assign bus.par_err = 1'b0;
`endif
endmodule
